// File: rtl/wb_arbiter_4to2_pkg.sv
// Shared widths and the result payload type for the write-back path.
package core_pkg;

    localparam int unsigned PREG_AW = 6;
    localparam int unsigned DATA_W  = 64;

    // One execution-unit result: destination preg plus its data.
    typedef struct packed {
        logic [PREG_AW-1:0] pdst;
        logic [DATA_W-1:0]  data;
    } wb_req_t;

    localparam int unsigned REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_arbiter_4to2_if.sv
// Result sources on one side, the two preg-file write ports on the other.
interface wb_arbiter_4to2_if #(
    parameter int unsigned NUM_SRC = 4
);
    import core_pkg::*;

    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*PREG_AW-1:0] src_pdst;
    logic [NUM_SRC*DATA_W-1:0]  src_data;
    logic [NUM_SRC-1:0]         src_ready;
    logic                       wren0;
    logic [PREG_AW-1:0]         waddr0;
    logic [DATA_W-1:0]          wdata0;
    logic                       wren1;
    logic [PREG_AW-1:0]         waddr1;
    logic [DATA_W-1:0]          wdata1;

    // Execution-unit / environment side.
    modport master (
        output src_valid, src_pdst, src_data,
        input  src_ready, wren0, waddr0, wdata0, wren1, waddr1, wdata1
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_pdst, src_data,
        output src_ready, wren0, waddr0, wdata0, wren1, waddr1, wdata1
    );

endinterface

// File: rtl/wb_arbiter_4to2_rr_pick2.sv
// Round-robin picker: first two valid sources in scan order starting at ptr.
module rr_pick2 #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         valid,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [NUM_SRC-1:0]         g0,
    output logic [NUM_SRC-1:0]         g1,
    output logic                       g0_vld,
    output logic                       g1_vld
);
    localparam int unsigned PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] rot;
    logic [NUM_SRC-1:0] rot_g0;
    logic [NUM_SRC-1:0] rot_g1;

    // (base + off) mod NUM_SRC, explicit wrap so non-power-of-2 counts work.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                   input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return PTR_W'(s);
    endfunction

    // Rotate so that position 0 is the current round-robin head.
    always_comb begin
        rot = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            rot[j] = valid[wrap_idx(ptr, j)];
        end
    end

    // Dual priority encode: lowest set bit, then the next one above it.
    always_comb begin
        rot_g0 = '0;
        rot_g1 = '0;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (rot[j]) begin
                if (!g0_vld) begin
                    rot_g0[j] = 1'b1;
                    g0_vld    = 1'b1;
                end else if (!g1_vld) begin
                    rot_g1[j] = 1'b1;
                    g1_vld    = 1'b1;
                end
            end
        end
    end

    // Rotate the one-hot grants back to source numbering.
    always_comb begin
        g0 = '0;
        g1 = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            g0[wrap_idx(ptr, j)] = rot_g0[j];
            g1[wrap_idx(ptr, j)] = rot_g1[j];
        end
    end

endmodule

// File: rtl/wb_arbiter_4to2.sv
// Write-back arbiter: grants up to two result sources per cycle onto the two
// preg-file write ports; the registered ports also serve as the wakeup bus.
module wb_arbiter_4to2
    import core_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    wb_arbiter_4to2_if.slave          bus
);
    localparam int unsigned PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   last_idx;
    logic [NUM_SRC-1:0] g0;
    logic [NUM_SRC-1:0] g1;
    logic [NUM_SRC-1:0] last_oh;
    logic               g0_vld;
    logic               g1_vld;
    wb_req_t            req [NUM_SRC];
    wb_req_t            sel0;
    wb_req_t            sel1;

    // Unpack the flat source buses into per-source payloads.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign req[i].pdst = bus.src_pdst[i*PREG_AW +: PREG_AW];
        assign req[i].data = bus.src_data[i*DATA_W +: DATA_W];
    end

    rr_pick2 #(.NUM_SRC(NUM_SRC)) u_pick (
        .valid  (bus.src_valid),
        .ptr    (ptr),
        .g0     (g0),
        .g1     (g1),
        .g0_vld (g0_vld),
        .g1_vld (g1_vld)
    );

    // Grants are only ever offered to valid sources, so ready alone marks a transfer.
    assign bus.src_ready = reset_n ? (g0 | g1) : '0;

    // One-hot payload muxes and next round-robin head after the last grant.
    always_comb begin
        sel0     = '0;
        sel1     = '0;
        last_idx = '0;
        last_oh  = g1_vld ? g1 : g0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (g0[i]) sel0 = req[i];
            if (g1[i]) sel1 = req[i];
            if (last_oh[i]) last_idx = PTR_W'(i);
        end
        if (last_idx == PTR_W'(NUM_SRC - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = PTR_W'(last_idx + 1'b1);
        end
    end

    // Output register bank and pointer; preg 0 is granted but never written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.wren0  <= 1'b0;
            bus.waddr0 <= '0;
            bus.wdata0 <= '0;
            bus.wren1  <= 1'b0;
            bus.waddr1 <= '0;
            bus.wdata1 <= '0;
            ptr        <= '0;
        end else begin
            bus.wren0 <= g0_vld && (sel0.pdst != '0);
            bus.wren1 <= g1_vld && (sel1.pdst != '0);
            if (g0_vld) begin
                bus.waddr0 <= sel0.pdst;
                bus.wdata0 <= sel0.data;
                ptr        <= ptr_nxt;
            end
            if (g1_vld) begin
                bus.waddr1 <= sel1.pdst;
                bus.wdata1 <= sel1.data;
            end
        end
    end

    // Renaming guarantees two same-cycle results never target the same live preg.
    a_no_pdst_clash: assert property (@(posedge clock) disable iff (!reset_n)
        !(g0_vld && g1_vld && (sel0.pdst != '0) && (sel0.pdst == sel1.pdst)));

endmodule

// File: tb/tb_wb_arbiter_4to2.sv
// Directed bench for wb_arbiter_4to2 with hand-computed expectations.
module tb_wb_arbiter_4to2;

    logic clock;
    logic reset_n;
    int   nvec;
    int   nerr;

    wb_arbiter_4to2_if #(.NUM_SRC(4)) bus ();

    wb_arbiter_4to2 #(.NUM_SRC(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input logic [5:0] pdst, input logic [63:0] data);
        bus.src_pdst[i*6 +: 6]   = pdst;
        bus.src_data[i*64 +: 64] = data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.src_valid = 4'b1111;
        set_src(0, 6'd5, 64'h100);
        set_src(1, 6'd6, 64'h101);
        set_src(2, 6'd7, 64'h102);
        set_src(3, 6'd8, 64'h103);
        tick();
        tick();
        nvec++; if (bus.src_ready !== 4'b0000) begin nerr++; $display("FAIL rst_ready: got %b want 0000", bus.src_ready); end
        nvec++; if (bus.wren0 !== 1'b0) begin nerr++; $display("FAIL rst_wren0: got %b want 0", bus.wren0); end
        nvec++; if (bus.wren1 !== 1'b0) begin nerr++; $display("FAIL rst_wren1: got %b want 0", bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd0 || bus.waddr1 !== 6'd0) begin nerr++; $display("FAIL rst_waddr: got %0d/%0d want 0/0", bus.waddr0, bus.waddr1); end
        nvec++; if (bus.wdata0 !== 64'd0 || bus.wdata1 !== 64'd0) begin nerr++; $display("FAIL rst_wdata: got %h/%h want 0/0", bus.wdata0, bus.wdata1); end
        reset_n = 1'b1;
    endtask

    task automatic test_all_valid();
        #1;
        nvec++; if (bus.src_ready !== 4'b0011) begin nerr++; $display("FAIL all_ready0: got %b want 0011", bus.src_ready); end
        tick();
        nvec++; if (bus.wren0 !== 1'b1 || bus.wren1 !== 1'b1) begin nerr++; $display("FAIL all_wren_a: got %b%b want 11", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd5 || bus.waddr1 !== 6'd6) begin nerr++; $display("FAIL all_waddr_a: got %0d/%0d want 5/6", bus.waddr0, bus.waddr1); end
        nvec++; if (bus.wdata0 !== 64'h100 || bus.wdata1 !== 64'h101) begin nerr++; $display("FAIL all_wdata_a: got %h/%h want 100/101", bus.wdata0, bus.wdata1); end
        bus.src_valid = 4'b1100;
        #1;
        nvec++; if (bus.src_ready !== 4'b1100) begin nerr++; $display("FAIL all_ready1: got %b want 1100", bus.src_ready); end
        tick();
        nvec++; if (bus.wren0 !== 1'b1 || bus.wren1 !== 1'b1) begin nerr++; $display("FAIL all_wren_b: got %b%b want 11", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd7 || bus.waddr1 !== 6'd8) begin nerr++; $display("FAIL all_waddr_b: got %0d/%0d want 7/8", bus.waddr0, bus.waddr1); end
        bus.src_valid = 4'b0000;
        #1;
        nvec++; if (bus.src_ready !== 4'b0000) begin nerr++; $display("FAIL idle_ready: got %b want 0000", bus.src_ready); end
        tick();
        nvec++; if (bus.wren0 !== 1'b0 || bus.wren1 !== 1'b0) begin nerr++; $display("FAIL idle_wren: got %b%b want 00", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd7 || bus.waddr1 !== 6'd8) begin nerr++; $display("FAIL idle_hold: got %0d/%0d want 7/8", bus.waddr0, bus.waddr1); end
    endtask

    task automatic test_single();
        set_src(2, 6'd9, 64'hDEAD);
        bus.src_valid = 4'b0100;
        #1;
        nvec++; if (bus.src_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b want 0100", bus.src_ready); end
        tick();
        bus.src_valid = 4'b0000;
        nvec++; if (bus.wren0 !== 1'b1 || bus.wren1 !== 1'b0) begin nerr++; $display("FAIL single_wren: got %b%b want 10", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd9 || bus.wdata0 !== 64'hDEAD) begin nerr++; $display("FAIL single_port0: got %0d/%h want 9/dead", bus.waddr0, bus.wdata0); end
    endtask

    task automatic test_wrap();
        set_src(3, 6'd10, 64'hA3);
        set_src(0, 6'd11, 64'hA0);
        bus.src_valid = 4'b1001;
        #1;
        nvec++; if (bus.src_ready !== 4'b1001) begin nerr++; $display("FAIL wrap_ready: got %b want 1001", bus.src_ready); end
        tick();
        nvec++; if (bus.waddr0 !== 6'd10 || bus.wdata0 !== 64'hA3) begin nerr++; $display("FAIL wrap_port0: got %0d/%h want 10/a3", bus.waddr0, bus.wdata0); end
        nvec++; if (bus.waddr1 !== 6'd11 || bus.wdata1 !== 64'hA0) begin nerr++; $display("FAIL wrap_port1: got %0d/%h want 11/a0", bus.waddr1, bus.wdata1); end
        set_src(0, 6'd16, 64'hB0);
        set_src(1, 6'd14, 64'hB1);
        set_src(2, 6'd15, 64'hB2);
        bus.src_valid = 4'b0111;
        #1;
        nvec++; if (bus.src_ready !== 4'b0110) begin nerr++; $display("FAIL wrap_ptr1_ready: got %b want 0110", bus.src_ready); end
        tick();
        nvec++; if (bus.waddr0 !== 6'd14 || bus.waddr1 !== 6'd15) begin nerr++; $display("FAIL wrap_ptr1_waddr: got %0d/%0d want 14/15", bus.waddr0, bus.waddr1); end
        bus.src_valid = 4'b0001;
        #1;
        nvec++; if (bus.src_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_pend_ready: got %b want 0001", bus.src_ready); end
        tick();
        nvec++; if (bus.wren0 !== 1'b1 || bus.wren1 !== 1'b0 || bus.waddr0 !== 6'd16) begin nerr++; $display("FAIL wrap_pend_port: got %b%b/%0d want 10/16", bus.wren0, bus.wren1, bus.waddr0); end
        set_src(3, 6'd13, 64'hB3);
        bus.src_valid = 4'b1000;
        tick();
        bus.src_valid = 4'b0000;
        nvec++; if (bus.waddr0 !== 6'd13) begin nerr++; $display("FAIL wrap_src3_waddr: got %0d want 13", bus.waddr0); end
    endtask

    task automatic test_zero_pdst();
        set_src(1, 6'd0, 64'h11);
        set_src(2, 6'd12, 64'h22);
        bus.src_valid = 4'b0110;
        #1;
        nvec++; if (bus.src_ready !== 4'b0110) begin nerr++; $display("FAIL zero_ready: got %b want 0110", bus.src_ready); end
        tick();
        bus.src_valid = 4'b0000;
        nvec++; if (bus.wren0 !== 1'b0 || bus.wren1 !== 1'b1) begin nerr++; $display("FAIL zero_wren: got %b%b want 01", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr1 !== 6'd12 || bus.wdata1 !== 64'h22) begin nerr++; $display("FAIL zero_port1: got %0d/%h want 12/22", bus.waddr1, bus.wdata1); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy [6];
        int cnt [4];
        int last [4];
        exp_rdy = '{4'b1001, 4'b0110, 4'b1001, 4'b0110, 4'b1001, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            cnt[i]  = 0;
            last[i] = -1;
        end
        set_src(0, 6'd5, 64'h200);
        set_src(1, 6'd6, 64'h201);
        set_src(2, 6'd7, 64'h202);
        set_src(3, 6'd8, 64'h203);
        bus.src_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            nvec++; if (bus.src_ready !== exp_rdy[c]) begin nerr++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, bus.src_ready, exp_rdy[c]); end
            for (int i = 0; i < 4; i++) begin
                if (bus.src_ready[i] === 1'b1) begin
                    if (last[i] >= 0 && c - last[i] > 2) begin
                        nvec++; nerr++; $display("FAIL b2b_gap src%0d: got gap %0d want <=2", i, c - last[i]);
                    end
                    last[i] = c;
                    cnt[i]++;
                end
            end
            tick();
            nvec++; if (bus.wren0 !== 1'b1 || bus.wren1 !== 1'b1) begin nerr++; $display("FAIL b2b_wren[%0d]: got %b%b want 11", c, bus.wren0, bus.wren1); end
        end
        bus.src_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            nvec++; if (cnt[i] != 3) begin nerr++; $display("FAIL b2b_count src%0d: got %0d want 3", i, cnt[i]); end
        end
    endtask

    task automatic test_reset_mid();
        set_src(0, 6'd20, 64'h77);
        bus.src_valid = 4'b0001;
        #1;
        nvec++; if (bus.src_ready !== 4'b0001) begin nerr++; $display("FAIL mid_ready: got %b want 0001", bus.src_ready); end
        tick();
        nvec++; if (bus.wren0 !== 1'b1 || bus.waddr0 !== 6'd20) begin nerr++; $display("FAIL mid_pre: got %b/%0d want 1/20", bus.wren0, bus.waddr0); end
        reset_n = 1'b0;
        bus.src_valid = 4'b0000;
        #1;
        nvec++; if (bus.wren0 !== 1'b0 || bus.wren1 !== 1'b0) begin nerr++; $display("FAIL mid_async_wren: got %b%b want 00", bus.wren0, bus.wren1); end
        nvec++; if (bus.waddr0 !== 6'd0 || bus.wdata0 !== 64'd0) begin nerr++; $display("FAIL mid_async_port0: got %0d/%h want 0/0", bus.waddr0, bus.wdata0); end
        tick();
        reset_n = 1'b1;
        set_src(0, 6'd5, 64'h300);
        set_src(1, 6'd6, 64'h301);
        set_src(2, 6'd7, 64'h302);
        set_src(3, 6'd8, 64'h303);
        bus.src_valid = 4'b1111;
        #1;
        nvec++; if (bus.src_ready !== 4'b0011) begin nerr++; $display("FAIL mid_post_ready: got %b want 0011", bus.src_ready); end
        tick();
        bus.src_valid = 4'b0000;
        nvec++; if (bus.waddr0 !== 6'd5 || bus.waddr1 !== 6'd6) begin nerr++; $display("FAIL mid_post_waddr: got %0d/%0d want 5/6", bus.waddr0, bus.waddr1); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        bus.src_valid = '0;
        bus.src_pdst  = '0;
        bus.src_data  = '0;
        test_reset();
        test_all_valid();
        test_single();
        test_wrap();
        test_zero_pdst();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
